mips_cpu_ifetch: RTL and testbench

Instruction fetch stage, directly downstream of the program counter. Accepts a fetch address over a valid/ready handshake and issues a single-word read on the instruction memory bus (Avalon-MM style with waitrequest). Holds the returned word, with its PC, until the decode stage consumes it. Supports flush on redirect (branch or jump) and halts when the PC reaches address 0.

---
 rtl/mips_cpu_pkg.sv | 17 +
 rtl/mips_cpu_ifetch.sv | 124 ++++++++++++
 tb/tb_mips_cpu_ifetch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: ifetch state encoding and the architectural
// reset/halt addresses used by both the PC stage and the fetch stage.
package mips_cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [XLEN-1:0] HALT_ADDR    = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } ifetch_state_t;

endpackage : mips_cpu_pkg

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch stage: takes a PC over valid/ready, performs one
// Avalon-MM read, and holds the word plus its PC until decode takes it.
// Optional build macro MIPS_CPU_IFETCH_ALIGN_CHECK_EN adds addr_fault and
// turns misaligned PCs into a faulting entry instead of a bus read.
module mips_cpu_ifetch
  import mips_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic [XLEN-1:0] mem_address,
  output logic            mem_read,
  input  logic            mem_waitrequest,
  input  logic [XLEN-1:0] mem_readdata,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc_out,
  output logic            instr_valid,
  input  logic            instr_ready,
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
  output logic            addr_fault,
`endif
  output logic            active
);

  ifetch_state_t   state;
  logic            drop;
  logic            consume;
  logic            accept;
  logic            is_halt;
  logic [XLEN-1:0] fetch_addr;

  // Held entry leaves on consume or redirect; a new PC may enter the same cycle.
  assign consume  = (state == HOLD) && (instr_ready || flush);
  assign pc_ready = (state == IDLE) || consume;
  assign accept   = pc_valid && pc_ready;
  assign is_halt  = (pc_in == HALT_ADDR);

`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (pc_in[1:0] != 2'b00);
  assign fetch_addr = pc_in;
`else
  // Without the check, the bus only ever sees word addresses.
  assign fetch_addr = {pc_in[XLEN-1:2], 2'b00};
`endif

  // Fetch FSM with registered bus and decode-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      drop         <= 1'b0;
      mem_read     <= 1'b0;
      mem_address  <= '0;
      instr_out    <= '0;
      instr_pc_out <= RESET_VECTOR;
      instr_valid  <= 1'b0;
      active       <= 1'b1;
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
      addr_fault   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (consume) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
            addr_fault  <= 1'b0;
`endif
          end
          if (accept) begin
            if (is_halt) begin
              state       <= HALTED;
              active      <= 1'b0;
              instr_valid <= 1'b0;
            end
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
            else if (misaligned) begin
              state        <= HOLD;
              instr_valid  <= 1'b1;
              instr_out    <= '0;
              instr_pc_out <= pc_in;
              addr_fault   <= 1'b1;
            end
`endif
            else begin
              state       <= READ;
              mem_address <= fetch_addr;
              mem_read    <= 1'b1;
              instr_valid <= 1'b0;
            end
          end
        end
        READ: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            drop     <= 1'b0;
            // A redirect seen at any point of the read discards its data.
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              state        <= HOLD;
              instr_out    <= mem_readdata;
              instr_pc_out <= mem_address;
              instr_valid  <= 1'b1;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mips_cpu_ifetch

// File: tb/tb_mips_cpu_ifetch.sv
// Self-checking bench for mips_cpu_ifetch: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_mips_cpu_ifetch;
  import mips_cpu_pkg::*;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic [XLEN-1:0] mem_address;
  logic            mem_read;
  logic            mem_waitrequest;
  logic [XLEN-1:0] mem_readdata;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc_out;
  logic            instr_valid;
  logic            instr_ready;
  logic            active;
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
  logic            addr_fault;
`endif

  int total = 0;
  int bad   = 0;

  mips_cpu_ifetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata   (mem_readdata),
    .instr_out      (instr_out),
    .instr_pc_out   (instr_pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
    .addr_fault     (addr_fault),
`endif
    .active         (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24020005;
    return {a[15:0] ^ 16'h1234, a[31:16]} ^ 32'h0F0F0F0F;
  endfunction

  // Reference model: what the stage currently owns, not how it sequences.
  bit          m_known = 1'b0;
  bit          m_halt, m_busy, m_drop, m_hold, m_fault;
  logic [31:0] m_addr, m_data, m_pc;

  task automatic step(input bit r, input bit pv, input logic [31:0] pc,
                      input bit fl, input bit wr, input bit ir);
    bit exp_ready;
    bit acc;
    rst             = r;
    pc_valid        = pv;
    pc_in           = pc;
    flush           = fl;
    mem_waitrequest = wr;
    instr_ready     = ir;
    mem_readdata    = mem_word(mem_address);
    #2;
    exp_ready = !m_halt && !m_busy && (!m_hold || ir || fl);
    if (m_known) check("pc_ready", 32'(pc_ready), 32'(exp_ready));
    @(posedge clk);
    if (r) begin
      m_known = 1'b1;
      m_halt = 0; m_busy = 0; m_drop = 0; m_hold = 0; m_fault = 0;
      m_addr = '0; m_data = '0; m_pc = RESET_VECTOR;
    end else if (m_known) begin
      acc = pv && exp_ready;
      if (m_busy) begin
        if (fl) m_drop = 1'b1;
        if (!wr) begin
          m_busy = 1'b0;
          if (!m_drop) begin
            m_hold = 1'b1;
            m_data = mem_word(m_addr);
            m_pc   = m_addr;
          end
          m_drop = 1'b0;
        end
      end else if (m_hold && (ir || fl)) begin
        m_hold  = 1'b0;
        m_fault = 1'b0;
      end
      if (acc) begin
        if (pc == HALT_ADDR) begin
          m_halt = 1'b1;
          m_hold = 1'b0;
        end
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
        else if (pc % 4 != 0) begin
          m_hold  = 1'b1;
          m_data  = '0;
          m_pc    = pc;
          m_fault = 1'b1;
        end
`endif
        else begin
          m_busy = 1'b1;
          m_hold = 1'b0;
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
          m_addr = pc;
`else
          m_addr = pc - (pc % 4);
`endif
        end
      end
    end
    #1;
    if (m_known) begin
      check("mem_read",     32'(mem_read),    32'(m_busy));
      check("mem_address",  mem_address,      m_addr);
      check("instr_valid",  32'(instr_valid), 32'(m_hold));
      check("instr_out",    instr_out,        m_data);
      check("instr_pc_out", instr_pc_out,     m_pc);
      check("active",       32'(active),      32'(!m_halt));
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
      check("addr_fault",   32'(addr_fault),  32'(m_fault));
`endif
    end
  endtask

  initial begin
    logic [31:0] pc;
    int          sel;
    rst = 1'b1; pc_valid = 1'b0; pc_in = '0; flush = 1'b0;
    mem_waitrequest = 1'b0; mem_readdata = '0; instr_ready = 1'b0;

    // Reset state
    step(1, 0, 32'h0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    check("rst_pc_tag", instr_pc_out, 32'hBFC00000);
    check("rst_active", 32'(active), 32'd1);

    // Zero-wait fetch: read at N+1, data at N+2
    step(0, 1, 32'hBFC00000, 0, 0, 0);
    check("z_read", 32'(mem_read), 32'd1);
    check("z_addr", mem_address, 32'hBFC00000);
    step(0, 0, 32'h0, 0, 0, 0);
    check("z_data", instr_out, 32'h24020005);
    check("z_valid", 32'(instr_valid), 32'd1);

    // Decode stalls for 4 cycles, then back-to-back accept with 3 wait states
    for (int i = 0; i < 4; i++) step(0, 1, 32'hBFC00004, 0, 0, 0);
    step(0, 1, 32'hBFC00004, 0, 0, 1);
    check("b2b_read", 32'(mem_read), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 1, 0);
    check("ws_addr_stable", mem_address, 32'hBFC00004);
    step(0, 0, 32'h0, 0, 0, 0);
    check("ws_pc", instr_pc_out, 32'hBFC00004);
    step(0, 0, 32'h0, 0, 0, 1);

    // Flush during a stalled read, then a clean redirect fetch
    step(0, 1, 32'hBFC00008, 0, 1, 0);
    step(0, 0, 32'h0, 1, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    check("flush_drop", 32'(instr_valid), 32'd0);
    step(0, 1, 32'hBFC00100, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    check("redirect_pc", instr_pc_out, 32'hBFC00100);
    step(0, 0, 32'h0, 1, 0, 0);
    check("flush_hold", 32'(instr_valid), 32'd0);

    // Misaligned PC
    step(0, 1, 32'hBFC00002, 0, 0, 0);
`ifdef MIPS_CPU_IFETCH_ALIGN_CHECK_EN
    check("mis_fault", 32'(addr_fault), 32'd1);
    check("mis_noread", 32'(mem_read), 32'd0);
`else
    check("mis_addr", mem_address, 32'hBFC00000);
`endif
    step(0, 0, 32'h0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 1);

    // Halt, then recover with reset
    step(0, 1, 32'h0, 0, 0, 0);
    check("halt_active", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'hBFC00000, 0, 0, 1);
    step(1, 0, 32'h0, 0, 0, 0);
    check("unhalt_active", 32'(active), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 2)       pc = HALT_ADDR;
      else if (sel < 10) pc = 32'hBFC00000 + ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
      else               pc = 32'hBFC00000 + ($urandom_range(0, 255) * 4);
      step(($urandom_range(0, 149) == 0) || (m_halt && $urandom_range(0, 7) == 0),
           $urandom_range(0, 9) < 6, pc,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mips_cpu_ifetch
